pipe_execute: RTL and testbench

Execute stage for the pipelined Y86-64 core, successor to the single-cycle SEQ execute block. It has a parametrised datapath width, a held condition-code register with exception-gated update, conditional-move destination cancelling, and the E→M pipeline register with stall/bubble control. The stage sits between the D→E register and the memory stage. It also feeds the forwarding unit combinationally.

---
 rtl/y86_pkg.sv | 48 ++++
 rtl/y86_alu.sv | 49 ++++
 rtl/pipe_execute.sv | 151 +++++++++++++++
 tb/tb_pipe_execute.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the pipelined core: instruction codes,
// status codes, the "no register" ID, ALU function and condition-function
// enumerations.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    // Status codes
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 4'd4;

    // Register ID meaning "no register" at the default 4-bit ID width
    localparam logic [3:0] RNONE = 4'hF;

    // OPQ function codes (ifun)
    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_fn_t;

    // Condition function codes (ifun of RRMOV/CMOV and JXX)
    typedef enum logic [3:0] {
        C_ALW = 4'd0,
        C_LE  = 4'd1,
        C_L   = 4'd2,
        C_E   = 4'd3,
        C_NE  = 4'd4,
        C_GE  = 4'd5,
        C_G   = 4'd6
    } cond_t;

endpackage

// File: rtl/y86_alu.sv
// Y86-64 integer ALU: ADD/SUB/AND/XOR on operands b (left) and a (right).
// Ports:
//   a, b    operands (result = b op a)
//   fn      ALU function
//   result  two's-complement result, modulo 2^DATA_W
//   zf, sf  zero / sign of result
//   of      signed overflow (ADD/SUB only, else 0)
module y86_alu
    import y86_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_fn_t           fn,
    output logic [DATA_W-1:0] result,
    output logic              zf,
    output logic              sf,
    output logic              of
);

    logic sa, sb, sr;

    assign sa = a[DATA_W-1];
    assign sb = b[DATA_W-1];
    assign sr = result[DATA_W-1];

    always_comb begin
        result = '0;
        of     = 1'b0;
        case (fn)
            ALU_ADD: begin
                result = b + a;
                of     = (sa == sb) && (sr != sa);
            end
            ALU_SUB: begin
                result = b - a;
                of     = (sa != sb) && (sr != sb);
            end
            ALU_AND: result = b & a;
            ALU_XOR: result = b ^ a;
            default: result = '0;
        endcase
    end

    assign zf = (result == '0);
    assign sf = sr;

endmodule

// File: rtl/pipe_execute.sv
// Execute stage of the pipelined Y86-64 core with the E->M pipeline register.
// Computes val_e, the branch/cmov condition from the held condition codes,
// updates the CC register for OPQ, and registers results into M.
// Ports:
//   clock, reset                    clock, synchronous active-high reset
//   e_*                             instruction currently in E
//   cc_block                        exception downstream: freeze CC
//   m_stall, m_bubble               E->M register hold / NOP-insert
//   m_*                             E->M register contents
//   fwd_val_e, fwd_dst_e            combinational results for forwarding
//   cc_zf, cc_sf, cc_of             held condition codes
module pipe_execute
    import y86_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int WORD_BYTES = 8,
    parameter int REG_W      = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        e_stat,
    input  logic [3:0]        e_icode,
    input  logic [3:0]        e_ifun,
    input  logic [DATA_W-1:0] e_val_a,
    input  logic [DATA_W-1:0] e_val_b,
    input  logic [DATA_W-1:0] e_val_c,
    input  logic [REG_W-1:0]  e_dst_e,
    input  logic [REG_W-1:0]  e_dst_m,
    input  logic              cc_block,
    input  logic              m_stall,
    input  logic              m_bubble,
    output logic [2:0]        m_stat,
    output logic [3:0]        m_icode,
    output logic              m_cnd,
    output logic [DATA_W-1:0] m_val_e,
    output logic [DATA_W-1:0] m_val_a,
    output logic [REG_W-1:0]  m_dst_e,
    output logic [REG_W-1:0]  m_dst_m,
    output logic [DATA_W-1:0] fwd_val_e,
    output logic [REG_W-1:0]  fwd_dst_e,
    output logic              cc_zf,
    output logic              cc_sf,
    output logic              cc_of
);

    // All-ones register ID at the configured width (RNONE when REG_W = 4)
    localparam logic [REG_W-1:0]  REG_NONE = {REG_W{1'b1}};
    localparam logic [DATA_W-1:0] STEP     = DATA_W'(WORD_BYTES);

    logic [DATA_W-1:0] alu_result;
    logic              alu_zf, alu_sf, alu_of;
    logic              opq_ok, cond_ok, is_cond_op;
    logic              cond_true, cnd;
    logic              force_ins, cc_write;
    logic [2:0]        stat_e;

    y86_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (e_val_a),
        .b      (e_val_b),
        .fn     (alu_fn_t'(e_ifun[1:0])),
        .result (alu_result),
        .zf     (alu_zf),
        .sf     (alu_sf),
        .of     (alu_of)
    );

    assign opq_ok     = (e_ifun <= 4'd3);
    assign cond_ok    = (e_ifun <= 4'd6);
    assign is_cond_op = (e_icode == I_RRMOV) || (e_icode == I_JXX);

    always_comb begin
        cond_true = 1'b0;
        case (e_ifun)
            C_ALW:   cond_true = 1'b1;
            C_LE:    cond_true = (cc_sf ^ cc_of) | cc_zf;
            C_L:     cond_true = cc_sf ^ cc_of;
            C_E:     cond_true = cc_zf;
            C_NE:    cond_true = ~cc_zf;
            C_GE:    cond_true = ~(cc_sf ^ cc_of);
            C_G:     cond_true = ~(cc_sf ^ cc_of) & ~cc_zf;
            default: cond_true = 1'b0;
        endcase
    end

    assign cnd = is_cond_op && cond_true;

    // Unknown ifun on OPQ or a condition-driven instruction is illegal
    assign force_ins = ((e_icode == I_OPQ) && !opq_ok) || (is_cond_op && !cond_ok);
    assign stat_e    = force_ins ? S_INS : e_stat;

    always_comb begin
        fwd_val_e = '0;
        case (e_icode)
            I_RRMOV:         fwd_val_e = e_val_a;
            I_IRMOV:         fwd_val_e = e_val_c;
            I_RMMOV, I_MRMOV: fwd_val_e = e_val_b + e_val_c;
            I_OPQ:           fwd_val_e = opq_ok ? alu_result : '0;
            I_CALL, I_PUSH:  fwd_val_e = e_val_b - STEP;
            I_RET, I_POP:    fwd_val_e = e_val_b + STEP;
            default:         fwd_val_e = '0;
        endcase
    end

    // A conditional move whose condition fails writes nowhere
    assign fwd_dst_e = ((e_icode == I_RRMOV) && !cnd) ? REG_NONE : e_dst_e;

    assign cc_write = (e_icode == I_OPQ) && opq_ok && (e_stat == S_AOK)
                      && !cc_block && !m_stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            cc_zf   <= 1'b1;
            cc_sf   <= 1'b0;
            cc_of   <= 1'b0;
            m_stat  <= S_AOK;
            m_icode <= I_NOP;
            m_cnd   <= 1'b0;
            m_val_e <= '0;
            m_val_a <= '0;
            m_dst_e <= REG_NONE;
            m_dst_m <= REG_NONE;
        end else begin
            // Bubbling M does not cancel the E instruction's CC write
            if (cc_write) begin
                cc_zf <= alu_zf;
                cc_sf <= alu_sf;
                cc_of <= alu_of;
            end
            if (m_stall) begin
                // hold all M contents
            end else if (m_bubble) begin
                m_stat  <= S_AOK;
                m_icode <= I_NOP;
                m_cnd   <= 1'b0;
                m_val_e <= '0;
                m_val_a <= '0;
                m_dst_e <= REG_NONE;
                m_dst_m <= REG_NONE;
            end else begin
                m_stat  <= stat_e;
                m_icode <= e_icode;
                m_cnd   <= cnd;
                m_val_e <= fwd_val_e;
                m_val_a <= e_val_a;
                m_dst_e <= fwd_dst_e;
                m_dst_m <= e_dst_m;
            end
        end
    end

endmodule

// File: tb/tb_pipe_execute.sv
// Directed self-checking bench for pipe_execute (default parameters).
module tb_pipe_execute;
    import y86_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  e_stat;
    logic [3:0]  e_icode, e_ifun;
    logic [63:0] e_val_a, e_val_b, e_val_c;
    logic [3:0]  e_dst_e, e_dst_m;
    logic        cc_block, m_stall, m_bubble;
    logic [2:0]  m_stat;
    logic [3:0]  m_icode;
    logic        m_cnd;
    logic [63:0] m_val_e, m_val_a;
    logic [3:0]  m_dst_e, m_dst_m;
    logic [63:0] fwd_val_e;
    logic [3:0]  fwd_dst_e;
    logic        cc_zf, cc_sf, cc_of;

    int checks = 0;
    int errors = 0;

    pipe_execute #(.DATA_W(64), .WORD_BYTES(8), .REG_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .e_stat    (e_stat),
        .e_icode   (e_icode),
        .e_ifun    (e_ifun),
        .e_val_a   (e_val_a),
        .e_val_b   (e_val_b),
        .e_val_c   (e_val_c),
        .e_dst_e   (e_dst_e),
        .e_dst_m   (e_dst_m),
        .cc_block  (cc_block),
        .m_stall   (m_stall),
        .m_bubble  (m_bubble),
        .m_stat    (m_stat),
        .m_icode   (m_icode),
        .m_cnd     (m_cnd),
        .m_val_e   (m_val_e),
        .m_val_a   (m_val_a),
        .m_dst_e   (m_dst_e),
        .m_dst_m   (m_dst_m),
        .fwd_val_e (fwd_val_e),
        .fwd_dst_e (fwd_dst_e),
        .cc_zf     (cc_zf),
        .cc_sf     (cc_sf),
        .cc_of     (cc_of)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cc(input string tag, input logic zf, input logic sf, input logic of);
        chk(tag, {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, zf, sf, of});
    endtask

    task automatic op(input logic [3:0] icode, input logic [3:0] ifun,
                      input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                      input logic [3:0] de, input logic [3:0] dm);
        e_stat  = S_AOK;
        e_icode = icode;
        e_ifun  = ifun;
        e_val_a = va;
        e_val_b = vb;
        e_val_c = vc;
        e_dst_e = de;
        e_dst_m = dm;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; cc_block = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
        op(I_NOP, 4'd0, 64'd0, 64'd0, 64'd0, RNONE, RNONE);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_icode", 64'(m_icode), 64'(I_NOP));
        chk("rst_stat", 64'(m_stat), 64'(S_AOK));
        chk("rst_dst_e", 64'(m_dst_e), 64'hF);
        chk("rst_val_e", m_val_e, 64'd0);
        chk_cc("rst_cc", 1'b1, 1'b0, 1'b0);

        // SUB 5-5 -> 0, ZF
        op(I_OPQ, 4'd1, 64'd5, 64'd5, 64'd0, 4'd3, RNONE);
        #1 chk("sub_fwd_val_e", fwd_val_e, 64'd0);
        tick();
        chk("sub_val_e", m_val_e, 64'd0);
        chk("sub_dst_e", 64'(m_dst_e), 64'd3);
        chk("sub_icode", 64'(m_icode), 64'(I_OPQ));
        chk_cc("sub_cc", 1'b1, 1'b0, 1'b0);

        // ADD 0x7FFF..F + 1 -> overflow
        op(I_OPQ, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'd4, RNONE);
        tick();
        chk("add_ovf_val_e", m_val_e, 64'h8000_0000_0000_0000);
        chk_cc("add_ovf_cc", 1'b0, 1'b1, 1'b1);

        // SUB 0x8000..0 - 1 -> overflow
        op(I_OPQ, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'd4, RNONE);
        tick();
        chk("sub_ovf_val_e", m_val_e, 64'h7FFF_FFFF_FFFF_FFFF);
        chk_cc("sub_ovf_cc", 1'b0, 1'b0, 1'b1);

        // AND and XOR
        op(I_OPQ, 4'd2, 64'h0F, 64'hF0, 64'd0, 4'd1, RNONE);
        tick();
        chk("and_val_e", m_val_e, 64'd0);
        chk_cc("and_cc", 1'b1, 1'b0, 1'b0);
        op(I_OPQ, 4'd3, 64'h0F, 64'hFF, 64'd0, 4'd1, RNONE);
        tick();
        chk("xor_val_e", m_val_e, 64'hF0);
        chk_cc("xor_cc", 1'b0, 1'b0, 1'b0);

        // SUB 3-5 -> -2, SF only
        op(I_OPQ, 4'd1, 64'd5, 64'd3, 64'd0, 4'd2, RNONE);
        tick();
        chk("sub_neg_val_e", m_val_e, 64'hFFFF_FFFF_FFFF_FFFE);
        chk_cc("sub_neg_cc", 1'b0, 1'b1, 1'b0);

        // CMOVG (false) cancels destination
        op(I_RRMOV, 4'd6, 64'h55, 64'd0, 64'd0, 4'd2, RNONE);
        #1 chk("cmovg_fwd_dst", 64'(fwd_dst_e), 64'hF);
        tick();
        chk("cmovg_cnd", 64'(m_cnd), 64'd0);
        chk("cmovg_dst_e", 64'(m_dst_e), 64'hF);
        chk("cmovg_val_e", m_val_e, 64'h55);
        chk("cmovg_val_a", m_val_a, 64'h55);

        // CMOVL (true) keeps destination
        op(I_RRMOV, 4'd2, 64'h66, 64'd0, 64'd0, 4'd5, RNONE);
        tick();
        chk("cmovl_cnd", 64'(m_cnd), 64'd1);
        chk("cmovl_dst_e", 64'(m_dst_e), 64'd5);

        // JL taken, JE not taken
        op(I_JXX, 4'd2, 64'h0, 64'd0, 64'h400, RNONE, RNONE);
        tick();
        chk("jl_cnd", 64'(m_cnd), 64'd1);
        chk("jl_val_e", m_val_e, 64'd0);
        op(I_JXX, 4'd3, 64'h0, 64'd0, 64'h400, RNONE, RNONE);
        tick();
        chk("je_cnd", 64'(m_cnd), 64'd0);

        // ADD 1+1 with cc_block
        op(I_OPQ, 4'd0, 64'd1, 64'd1, 64'd0, 4'd6, RNONE);
        cc_block = 1'b1;
        tick();
        cc_block = 1'b0;
        chk("ccblk_val_e", m_val_e, 64'd2);
        chk_cc("ccblk_cc", 1'b0, 1'b1, 1'b0);

        // Stall: M holds, CC held
        op(I_OPQ, 4'd0, 64'd3, 64'd4, 64'd0, 4'd7, RNONE);
        m_stall = 1'b1;
        #1 chk("stall_fwd_val_e", fwd_val_e, 64'd7);
        tick();
        chk("stall_val_e", m_val_e, 64'd2);
        chk("stall_dst_e", 64'(m_dst_e), 64'd6);
        chk_cc("stall_cc", 1'b0, 1'b1, 1'b0);

        // Stall + bubble: stall wins
        op(I_OPQ, 4'd0, 64'd0, 64'd0, 64'd0, 4'd7, RNONE);
        m_bubble = 1'b1;
        tick();
        m_stall = 1'b0; m_bubble = 1'b0;
        chk("stbub_icode", 64'(m_icode), 64'(I_OPQ));
        chk("stbub_val_e", m_val_e, 64'd2);
        chk_cc("stbub_cc", 1'b0, 1'b1, 1'b0);

        // Stack arithmetic
        op(I_CALL, 4'd0, 64'd0, 64'h100, 64'h200, 4'd4, RNONE);
        tick();
        chk("call_val_e", m_val_e, 64'hF8);
        op(I_POP, 4'd0, 64'h100, 64'h100, 64'd0, 4'd4, 4'd1);
        tick();
        chk("pop_val_e", m_val_e, 64'h108);
        chk("pop_dst_m", 64'(m_dst_m), 64'd1);
        op(I_PUSH, 4'd0, 64'd9, 64'h100, 64'd0, 4'd4, RNONE);
        tick();
        chk("push_val_e", m_val_e, 64'hF8);
        op(I_RET, 4'd0, 64'd0, 64'h100, 64'd0, 4'd4, RNONE);
        tick();
        chk("ret_val_e", m_val_e, 64'h108);

        // Memory address and immediate
        op(I_MRMOV, 4'd0, 64'd0, 64'h10, 64'h20, RNONE, 4'd3);
        tick();
        chk("mrmov_val_e", m_val_e, 64'h30);
        op(I_IRMOV, 4'd0, 64'd0, 64'd0, 64'h1234, 4'd3, RNONE);
        tick();
        chk("irmov_val_e", m_val_e, 64'h1234);

        // Illegal OPQ ifun 7
        op(I_OPQ, 4'd7, 64'd0, 64'd0, 64'd0, 4'd1, RNONE);
        tick();
        chk("opq7_stat", 64'(m_stat), 64'(S_INS));
        chk("opq7_val_e", m_val_e, 64'd0);
        chk_cc("opq7_cc", 1'b0, 1'b1, 1'b0);

        // Illegal JXX ifun 7
        op(I_JXX, 4'd7, 64'd0, 64'd0, 64'd0, RNONE, RNONE);
        tick();
        chk("jxx7_stat", 64'(m_stat), 64'(S_INS));
        chk("jxx7_cnd", 64'(m_cnd), 64'd0);

        // Bubble with valid OPQ: NOP into M, CC still updates
        op(I_OPQ, 4'd0, 64'd0, 64'd0, 64'd0, 4'd2, RNONE);
        m_bubble = 1'b1;
        tick();
        m_bubble = 1'b0;
        chk("bub_icode", 64'(m_icode), 64'(I_NOP));
        chk("bub_stat", 64'(m_stat), 64'(S_AOK));
        chk("bub_dst_e", 64'(m_dst_e), 64'hF);
        chk("bub_val_e", m_val_e, 64'd0);
        chk_cc("bub_cc", 1'b1, 1'b0, 1'b0);

        // Non-AOK OPQ does not update CC; HALT status passes through
        op(I_OPQ, 4'd0, 64'd1, 64'd1, 64'd0, 4'd2, RNONE);
        e_stat = S_ADR;
        tick();
        chk("adr_stat", 64'(m_stat), 64'(S_ADR));
        chk_cc("adr_cc", 1'b1, 1'b0, 1'b0);
        op(I_HALT, 4'd0, 64'd0, 64'd0, 64'd0, RNONE, RNONE);
        e_stat = S_HLT;
        tick();
        chk("halt_stat", 64'(m_stat), 64'(S_HLT));
        chk("halt_icode", 64'(m_icode), 64'(I_HALT));

        // Mid-stream reset discards E instruction
        op(I_OPQ, 4'd0, 64'd1, 64'd1, 64'd0, 4'd2, RNONE);
        tick();
        chk_cc("pre_rst_cc", 1'b0, 1'b0, 1'b0);
        op(I_OPQ, 4'd0, 64'd5, 64'd5, 64'd0, 4'd3, RNONE);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_icode", 64'(m_icode), 64'(I_NOP));
        chk("midrst_val_e", m_val_e, 64'd0);
        chk_cc("midrst_cc", 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
